// File: rtl/sniffer_stream_packer.sv
// Frames capture-FIFO words into header+data packets on a valid/ready stream with tlast.
// Optional trailing XOR checksum word when PACKER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module sniffer_stream_packer #(
  parameter int          DATA_W    = 64,
  parameter int          BURST_LEN = 16,
  parameter int          TIMEOUT   = 256,
  parameter logic [15:0] MAGIC     = 16'hA55A
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              out_tlast,
  output logic              pkt_done,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_LAST = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       seq;
  logic [DATA_W-1:0] hdr_word;
`ifdef PACKER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign state_dbg = state;

  always_comb begin
    hdr_word = '0;
    hdr_word[DATA_W-1 -: 32] = {MAGIC, seq};
  end

  // Both streams transfer on a rising edge where valid && ready; a raised valid
  // keeps its data/tlast stable until that edge. In DATA the held word is passed
  // only while a new input word is offered, so hold always stays full.
  always_comb begin
    in_ready   = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    case (state)
      ST_IDLE: in_ready = s_aresetn;
      ST_HDR: begin
        out_tvalid = 1'b1;
        out_tdata  = hdr_word;
      end
      ST_DATA: begin
        out_tvalid = in_valid;
        in_ready   = out_tready;
        out_tdata  = hold;
      end
      ST_LAST: begin
        out_tvalid = 1'b1;
        out_tdata  = hold;
`ifdef PACKER_CHECKSUM_EN
        out_tlast  = 1'b0;
`else
        out_tlast  = 1'b1;
`endif
      end
`ifdef PACKER_CHECKSUM_EN
      ST_CSUM: begin
        out_tvalid = 1'b1;
        out_tdata  = csum;
        out_tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state    <= ST_IDLE;
      hold     <= '0;
      cnt      <= '0;
      timer    <= '0;
      seq      <= '0;
      pkt_done <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            cnt   <= CNT_W'(1);
            timer <= '0;
`ifdef PACKER_CHECKSUM_EN
            csum  <= in_data;
`endif
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_tready) state <= (cnt == CNT_W'(BURST_LEN)) ? ST_LAST : ST_DATA;
        end
        ST_DATA: begin
          if (in_valid) begin
            // A word arriving in the expiry cycle keeps the packet open.
            if (out_tready) begin
              hold  <= in_data;
              cnt   <= cnt + CNT_W'(1);
              timer <= '0;
`ifdef PACKER_CHECKSUM_EN
              csum  <= csum ^ in_data;
`endif
              if (cnt == CNT_W'(BURST_LEN - 1)) state <= ST_LAST;
            end
          end else begin
            timer <= timer + TMR_W'(1);
            if (timer == TMR_W'(TIMEOUT - 1)) state <= ST_LAST;
          end
        end
        ST_LAST: begin
          if (out_tready) begin
`ifdef PACKER_CHECKSUM_EN
            state    <= ST_CSUM;
`else
            seq      <= seq + 16'd1;
            pkt_done <= 1'b1;
            state    <= ST_IDLE;
`endif
          end
        end
`ifdef PACKER_CHECKSUM_EN
        ST_CSUM: begin
          if (out_tready) begin
            seq      <= seq + 16'd1;
            pkt_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sniffer_stream_packer.sv
// Scoreboard bench for sniffer_stream_packer: expected packet words are queued
// as words are driven and compared as the output stream handshakes.
`timescale 1ns/1ps
module tb_sniffer_stream_packer;

  localparam int DW = 64;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          s_aclk = 1'b0;
  logic          s_aresetn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic          pkt_done;
  logic [2:0]    state_dbg;

  sniffer_stream_packer #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO), .MAGIC(16'hA55A)) dut (
    .s_aclk(s_aclk), .s_aresetn(s_aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .pkt_done(pkt_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 s_aclk = ~s_aclk;

  int            total = 0;
  int            bad = 0;
  logic [DW:0]   exp_q[$];
  int            gap_q[$];
  logic [15:0]   seq_m = '0;
  logic [DW-1:0] pw[8];
  logic          tog_on = 1'b0;
  int            tog_mode = 0;

  task automatic check(input string tag, input logic [DW+1:0] act, input logic [DW+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: expected packet = header, data words, tail (tlast), plus idle gap before tlast
  task automatic push_pkt(input logic [DW-1:0] w[8], input int n, input int gap);
    logic [DW-1:0] cs;
    exp_q.push_back({1'b0, 16'hA55A, seq_m, 32'h0});
    cs = '0;
    for (int i = 0; i < n; i++) cs = cs ^ w[i];
    for (int i = 0; i < n - 1; i++) exp_q.push_back({1'b0, w[i]});
`ifdef PACKER_CHECKSUM_EN
    exp_q.push_back({1'b0, w[n-1]});
    exp_q.push_back({1'b1, cs});
    gap_q.push_back(0);
`else
    exp_q.push_back({1'b1, w[n-1]});
    gap_q.push_back(gap);
`endif
    seq_m = seq_m + 16'd1;
  endtask

  // output monitor, sampled on the falling edge
  logic          stall_p = 1'b0;
  logic [DW:0]   stall_v = '0;
  logic          done_p = 1'b0;
  int            gap = 0;

  always @(negedge s_aclk) begin
    if (!s_aresetn) begin
      stall_p <= 1'b0;
      done_p  <= 1'b0;
      gap     <= 0;
    end else begin
      if (done_p || pkt_done) check("pkt_done", {{DW+1{1'b0}}, pkt_done}, {{DW+1{1'b0}}, done_p});
      if (stall_p) check("stall_stable", {out_tvalid, out_tlast, out_tdata}, {1'b1, stall_v});
      if (out_tvalid && !out_tready) check("stall_in_ready", {{DW+1{1'b0}}, in_ready}, '0);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", DW'(exp_q.size()), 1);
        end else begin
          check("out_word", {1'b0, out_tlast, out_tdata}, {1'b0, exp_q.pop_front()});
          if (out_tlast && gap_q.size() > 0) check("idle_gap", DW'(gap), DW'(gap_q.pop_front()));
        end
        gap <= 0;
      end else if (!out_tvalid) begin
        gap <= gap + 1;
      end
      done_p  <= out_tvalid && out_tready && out_tlast;
      stall_p <= out_tvalid && !out_tready;
      stall_v <= {out_tlast, out_tdata};
    end
  end

  // driver tasks: inputs change 2ns after the rising edge
  task automatic drive_word(input logic [DW-1:0] d);
    int   n = 0;
    logic acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge s_aclk);
      acc = in_ready;
      @(posedge s_aclk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("in_accept_timeout", {{DW+1{1'b0}}, acc}, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge s_aclk);
      n++;
    end while (!pkt_done && n < 100);
    if (!pkt_done) check(tag, {{DW+1{1'b0}}, pkt_done}, 1);
  endtask

  task automatic do_reset();
    s_aresetn = 1'b0;
    #1;
    check("reset_outs", {in_ready, out_tvalid, out_tlast, pkt_done, state_dbg, out_tdata[DW-6:0]}, '0);
    repeat (2) @(posedge s_aclk);
    #2;
    s_aresetn = 1'b1;
    seq_m = '0;
    @(posedge s_aclk);
    #2;
  endtask

  task automatic run_toggler();
    int k = 0;
    while (tog_on) begin
      @(posedge s_aclk);
      #2;
      if (!tog_on) break;
      if (tog_mode == 0) out_tready = (k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1;
      else out_tready = 1'($urandom_range(0, 1));
      k++;
    end
    out_tready = 1'b1;
  endtask

  initial begin
    int n;
    do_reset();
    check("reset_tdata", {2'b0, out_tdata}, '0);

    // words 1..4 back-to-back: full packet
    for (int i = 0; i < 4; i++) pw[i] = DW'(i + 1);
    push_pkt(pw, 4, 0);
    for (int i = 0; i < 4; i++) drive_word(DW'(i + 1));
    wait_done("done_s1");
    @(posedge s_aclk); #2;

    // words 1..6: full packet then a timed-out one
    do_reset();
    for (int i = 0; i < 4; i++) pw[i] = DW'(i + 1);
    push_pkt(pw, 4, 0);
    pw[0] = 64'd5; pw[1] = 64'd6;
    push_pkt(pw, 2, TO);
    for (int i = 0; i < 6; i++) drive_word(DW'(i + 1));
    wait_done("done_s2");
    @(posedge s_aclk); #2;

    // single word then silence
    do_reset();
    pw[0] = 64'h55;
    push_pkt(pw, 1, TO);
    drive_word(64'h55);
    wait_done("done_s3");
    check("ready_after_pkt", {{DW+1{1'b0}}, in_ready}, 1);
    @(posedge s_aclk); #2;

    // downstream stalls on a 1,0,0,1 pattern
    for (int i = 0; i < 4; i++) pw[i] = DW'(i + 1);
    push_pkt(pw, 4, 0);
    tog_mode = 0;
    tog_on = 1'b1;
    fork run_toggler(); join_none
    for (int i = 0; i < 4; i++) drive_word(DW'(i + 1));
    wait_done("done_s4");
    tog_on = 1'b0;
    repeat (2) @(posedge s_aclk);
    #2;

    // reset in the middle of DATA
    exp_q.push_back({1'b0, 16'hA55A, seq_m, 32'h0});
    exp_q.push_back({1'b0, 64'd1});
    drive_word(64'd1);
    drive_word(64'd2);
    do_reset();
    check("rst_queue_empty", DW'(exp_q.size()), 0);
    pw[0] = 64'd9;
    push_pkt(pw, 1, TO);
    drive_word(64'd9);
    wait_done("done_s5");
    @(posedge s_aclk); #2;

    // random packets under random back-pressure
    tog_mode = 1;
    tog_on = 1'b1;
    fork run_toggler(); join_none
    for (int p = 0; p < 5; p++) begin
      n = $urandom_range(1, BL);
      for (int i = 0; i < n; i++) pw[i] = {$urandom, $urandom};
      push_pkt(pw, n, (n == BL) ? 0 : TO);
      for (int i = 0; i < n; i++) drive_word(pw[i]);
      wait_done("done_rand");
      @(posedge s_aclk); #2;
    end
    tog_on = 1'b0;
    repeat (4) @(posedge s_aclk);
    #2;

    check("final_queue_empty", DW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
